// File: rtl/dice_pkg.sv
// Shared constants, FSM state encoding and BCD helpers for the dice roller.
package dice_pkg;

  localparam int unsigned NUM_DIE    = 7;
  localparam int unsigned CNT_DIGITS = 3;
  localparam int unsigned CNT_W      = 4 * CNT_DIGITS;
  localparam int unsigned SEL_W      = 3;

  typedef logic [0:0] state_t;
  localparam state_t IDLE    = 1'b0;
  localparam state_t ROLLING = 1'b1;

  // Die maxima in BCD; entry 0 is d4, entry 6 is d100.
  localparam logic [NUM_DIE-1:0][CNT_W-1:0] DIE_MAX = {
    12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004
  };

  function automatic logic [CNT_W-1:0] die_max(input logic [SEL_W-1:0] sel);
    logic [CNT_W-1:0] m;
    m = DIE_MAX[0];
    for (int i = 0; i < NUM_DIE; i++) begin
      if (sel == SEL_W'(i)) m = DIE_MAX[i];
    end
    return m;
  endfunction

  // Lowest set bit index of a button vector.
  function automatic logic [SEL_W-1:0] first_set(input logic [NUM_DIE-1:0] v);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_DIE - 1; i >= 0; i--) begin
      if (v[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // BCD decrement; 1 (or an unexpected 0) wraps to the die maximum.
  function automatic logic [CNT_W-1:0] bcd_dec_wrap(input logic [CNT_W-1:0] v,
                                                    input logic [CNT_W-1:0] max);
    logic [CNT_W-1:0] r;
    logic             borrow;
    logic [3:0]       d;
    r      = v;
    borrow = 1'b1;
    if (v == CNT_W'(1) || v == '0) begin
      r = max;
    end else begin
      for (int i = 0; i < CNT_DIGITS; i++) begin
        d = v[4*i +: 4];
        if (borrow) begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Tick-sampled debouncer: level flips after DEB_COUNT consecutive differing samples.
module btn_debouncer #(
  parameter int unsigned DEB_COUNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic button,
  output logic debounced
);

  localparam int unsigned     DEB_W    = 4;
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_COUNT - 1);

  logic             r_level;
  logic [DEB_W-1:0] r_cnt;
  logic             w_level_nxt;
  logic [DEB_W-1:0] w_cnt_nxt;

  always_comb begin
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    if (tick) begin
      if (button == r_level) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_level_nxt = ~r_level;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign debounced = r_level;

endmodule

// File: rtl/dice_roller_bcd.sv
// Seven-die BCD roller: spins while the locked button is held, latches on release.
// Optional macro DICE_ROLL_ANIM_EN shows the spinning count on each tick.
module dice_roller_bcd
  import dice_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned DEB_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [NUM_DIE-1:0]    btn,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [SEL_W-1:0]      die_sel,
  output logic                  rolling,
  output logic                  result_valid
);

  localparam int unsigned OUT_W = 4 * DIGITS;

  logic               r_tick_en;
  logic               w_tick;
  logic [NUM_DIE-1:0] w_deb;
  logic [NUM_DIE-1:0] r_deb_prev;
  logic [NUM_DIE-1:0] w_rise;
  logic               w_locked;
  logic [OUT_W-1:0]   w_cnt_disp;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [OUT_W-1:0]   r_bcd, w_bcd_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_rolling, w_rolling_nxt;

  // Ignore a tick coinciding with the first cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_en  <= 1'b0;
      r_deb_prev <= '0;
    end else begin
      r_tick_en  <= 1'b1;
      r_deb_prev <= w_deb;
    end
  end

  assign w_tick = tick & r_tick_en;
  assign w_rise = w_deb & ~r_deb_prev;

  for (genvar g = 0; g < NUM_DIE; g++) begin : g_deb
    btn_debouncer #(
      .DEB_COUNT (DEB_COUNT)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (w_tick),
      .button    (btn[g]),
      .debounced (w_deb[g])
    );
  end

  // Truncate or zero-extend the 3-digit count to the display width.
  for (genvar g = 0; g < DIGITS; g++) begin : g_disp
    if (g < CNT_DIGITS) begin : g_cnt
      assign w_cnt_disp[4*g +: 4] = r_cnt[4*g +: 4];
    end else begin : g_zero
      assign w_cnt_disp[4*g +: 4] = 4'h0;
    end
  end

  always_comb begin
    w_locked = 1'b0;
    for (int i = 0; i < NUM_DIE; i++) begin
      if (r_sel == SEL_W'(i)) w_locked = w_deb[i];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_bcd_nxt     = r_bcd;
    w_valid_nxt   = 1'b0;
    w_rolling_nxt = r_rolling;
    case (r_state)
      IDLE: begin
        if (|w_rise) begin
          w_sel_nxt     = first_set(w_rise);
          w_cnt_nxt     = die_max(w_sel_nxt);
          w_state_nxt   = ROLLING;
          w_rolling_nxt = 1'b1;
        end
      end
      ROLLING: begin
        if (!w_locked) begin
          w_state_nxt   = IDLE;
          w_rolling_nxt = 1'b0;
          w_bcd_nxt     = w_cnt_disp;
          w_valid_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = bcd_dec_wrap(r_cnt, die_max(r_sel));
`ifdef DICE_ROLL_ANIM_EN
          if (w_tick) w_bcd_nxt = w_cnt_disp;
`endif
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_rolling_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_bcd     <= OUT_W'(1);
      r_valid   <= 1'b0;
      r_rolling <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sel     <= w_sel_nxt;
      r_bcd     <= w_bcd_nxt;
      r_valid   <= w_valid_nxt;
      r_rolling <= w_rolling_nxt;
    end
  end

  assign bcd_out      = r_bcd;
  assign die_sel      = r_sel;
  assign rolling      = r_rolling;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_dice_roller_bcd.sv
// Bench for dice_roller_bcd: one slow-debounce 2-digit DUT and a fast-debounce 2/3-digit pair.
module tb_dice_roller_bcd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [6:0]  btn_s, btn_f;

  logic [7:0]  bcd_s, bcd_f2;
  logic [11:0] bcd_f3;
  logic [2:0]  sel_s, sel_f2, sel_f3;
  logic        roll_s, roll_f2, roll_f3;
  logic        rv_s, rv_f2, rv_f3;

  int checks   = 0;
  int failures = 0;

`ifdef DICE_ROLL_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  always #5 clk = ~clk;

  dice_roller_bcd #(.DIGITS(2), .DEB_COUNT(2)) u_s (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_s),
    .bcd_out(bcd_s), .die_sel(sel_s), .rolling(roll_s), .result_valid(rv_s));

  dice_roller_bcd #(.DIGITS(2), .DEB_COUNT(1)) u_f2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_f),
    .bcd_out(bcd_f2), .die_sel(sel_f2), .rolling(roll_f2), .result_valid(rv_f2));

  dice_roller_bcd #(.DIGITS(3), .DEB_COUNT(1)) u_f3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_f),
    .bcd_out(bcd_f3), .die_sel(sel_f3), .rolling(roll_f3), .result_valid(rv_f3));

  // Edge counters of cycles with rolling / result_valid high.
  int roll_cnt_s = 0, rv_cnt_s = 0, roll_cnt_f = 0, rv_cnt_f2 = 0, rv_cnt_f3 = 0;
  logic last_tick = 1'b0;
  always @(posedge clk) begin
    if (roll_s === 1'b1)  roll_cnt_s <= roll_cnt_s + 1;
    if (rv_s === 1'b1)    rv_cnt_s   <= rv_cnt_s + 1;
    if (roll_f2 === 1'b1) roll_cnt_f <= roll_cnt_f + 1;
    if (rv_f2 === 1'b1)   rv_cnt_f2  <= rv_cnt_f2 + 1;
    if (rv_f3 === 1'b1)   rv_cnt_f3  <= rv_cnt_f3 + 1;
    last_tick <= tick;
  end

  // Display may only move on a latch, or on a tick when the spin animation is built in.
  int         disp_viol = 0;
  logic       prev_rst;
  logic [7:0] prev_bcd_s, prev_bcd_f2;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_rst === 1'b1) begin
      if (bcd_s !== prev_bcd_s && !(rv_s === 1'b1 || (ANIM && last_tick)))
        disp_viol = disp_viol + 1;
      if (bcd_f2 !== prev_bcd_f2 && !(rv_f2 === 1'b1 || (ANIM && last_tick)))
        disp_viol = disp_viol + 1;
    end
    prev_rst    = rst_n;
    prev_bcd_s  = bcd_s;
    prev_bcd_f2 = bcd_f2;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; drives tick high for k consecutive edges.
  task automatic tick_run(input int k);
    for (int i = 0; i < k; i++) begin
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  // Press, hold so rolling stays high exactly n cycles, release; ends on the latch cycle.
  task automatic drive_roll(input int grp, input int idx, input int n);
    int d;
    d = (grp == 0) ? 2 : 1;
    if (grp == 0) btn_s[idx] = 1'b1;
    else          btn_f[idx] = 1'b1;
    tick_run(d);
    repeat (n - d) @(negedge clk);
    btn_s = '0;
    btn_f = '0;
    tick_run(d);
    @(negedge clk);
  endtask

  typedef struct {
    int          grp;
    int          idx;
    int          n;
    logic [7:0]  exp2;
    logic [11:0] exp3;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int b_roll, b_rv, b_rv3;
    vecs[0]  = '{0, 1,   8, 8'h05, 12'h005};
    vecs[1]  = '{0, 0,   2, 8'h03, 12'h003};
    vecs[2]  = '{0, 5,  21, 8'h20, 12'h020};
    vecs[3]  = '{0, 3,  13, 8'h08, 12'h008};
    vecs[4]  = '{0, 6,   3, 8'h98, 12'h098};
    vecs[5]  = '{1, 6,   1, 8'h00, 12'h100};
    vecs[6]  = '{1, 6,   2, 8'h99, 12'h099};
    vecs[7]  = '{1, 4,   5, 8'h08, 12'h008};
    vecs[8]  = '{1, 2,   9, 8'h08, 12'h008};
    vecs[9]  = '{1, 6, 101, 8'h00, 12'h100};
    vecs[10] = '{1, 6,  12, 8'h89, 12'h089};
    vecs[11] = '{1, 3,  10, 8'h01, 12'h001};
    vecs[12] = '{1, 0,   4, 8'h01, 12'h001};

    rst_n = 1'b0;
    tick  = 1'b0;
    btn_s = '0;
    btn_f = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd_s",  16'(bcd_s),  16'h0001);
    check("rst_bcd_f3", 16'(bcd_f3), 16'h0001);
    check("rst_roll",   16'({roll_s, roll_f2, roll_f3}), 16'h0000);
    check("rst_valid",  16'({rv_s, rv_f2, rv_f3}),       16'h0000);
    check("rst_sel",    16'({sel_s, sel_f2, sel_f3}),    16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One-tick glitch on d10 must not start a roll.
    b_roll = roll_cnt_s;
    b_rv   = rv_cnt_s;
    btn_s[3] = 1'b1;
    tick_run(1);
    btn_s[3] = 1'b0;
    tick_run(2);
    repeat (3) @(negedge clk);
    check("glitch_roll", 16'(roll_cnt_s - b_roll), 16'h0000);
    check("glitch_rv",   16'(rv_cnt_s - b_rv),     16'h0000);
    check("glitch_bcd",  16'(bcd_s),              16'h0001);

    for (int i = 0; i < 13; i++) begin
      b_roll = (vecs[i].grp == 0) ? roll_cnt_s : roll_cnt_f;
      b_rv   = (vecs[i].grp == 0) ? rv_cnt_s : rv_cnt_f2;
      b_rv3  = rv_cnt_f3;
      drive_roll(vecs[i].grp, vecs[i].idx, vecs[i].n);
      if (vecs[i].grp == 0) begin
        check($sformatf("v%0d_roll", i), 16'(roll_s), 16'h0000);
        check($sformatf("v%0d_rv",   i), 16'(rv_s),   16'h0001);
        check($sformatf("v%0d_bcd",  i), 16'(bcd_s),  16'(vecs[i].exp2));
        check($sformatf("v%0d_sel",  i), 16'(sel_s),  16'(vecs[i].idx));
      end else begin
        check($sformatf("v%0d_roll",  i), 16'({roll_f2, roll_f3}), 16'h0000);
        check($sformatf("v%0d_rv",    i), 16'({rv_f2, rv_f3}),     16'h0003);
        check($sformatf("v%0d_bcd2",  i), 16'(bcd_f2), 16'(vecs[i].exp2));
        check($sformatf("v%0d_bcd3",  i), 16'(bcd_f3), 16'(vecs[i].exp3));
        check($sformatf("v%0d_sel",   i), 16'({sel_f2, sel_f3}),
              16'({3'(vecs[i].idx), 3'(vecs[i].idx)}));
      end
      @(negedge clk);
      if (vecs[i].grp == 0) begin
        check($sformatf("v%0d_ncyc",   i), 16'(roll_cnt_s - b_roll), 16'(vecs[i].n));
        check($sformatf("v%0d_pulses", i), 16'(rv_cnt_s - b_rv),     16'h0001);
      end else begin
        check($sformatf("v%0d_ncyc",   i), 16'(roll_cnt_f - b_roll), 16'(vecs[i].n));
        check($sformatf("v%0d_pulses", i), 16'({8'(rv_cnt_f2 - b_rv), 8'(rv_cnt_f3 - b_rv3)}),
              16'h0101);
      end
    end

    // d4 and d20 together: d4 wins; d20 activity is ignored during and after the roll.
    b_rv  = rv_cnt_s;
    btn_s = 7'b0100001;
    tick_run(2);
    @(negedge clk);
    check("sim_roll_start", 16'(roll_s), 16'h0001);
    check("sim_sel",        16'(sel_s),  16'h0000);
    btn_s[5] = 1'b0;
    tick_run(2);
    repeat (2) @(negedge clk);
    check("sim_d20_release", 16'(roll_s), 16'h0001);
    btn_s[5] = 1'b1;
    tick_run(2);
    check("sim_d20_repress", 16'({roll_s, sel_s}), 16'h0008);
    btn_s[0] = 1'b0;
    tick_run(2);
    @(negedge clk);
    check("sim_result_rv",    16'(rv_s), 16'h0001);
    check("sim_result_range", 16'(bcd_s >= 8'h01 && bcd_s <= 8'h04), 16'h0001);
    b_roll = roll_cnt_s;
    tick_run(4);
    repeat (4) @(negedge clk);
    check("sim_no_restart", 16'(roll_cnt_s - b_roll), 16'h0000);
    check("sim_pulses",     16'(rv_cnt_s - b_rv),     16'h0001);
    btn_s = '0;
    tick_run(2);
    repeat (2) @(negedge clk);

    // Tick coinciding with reset release is not sampled.
    rst_n    = 1'b0;
    btn_f[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("rst_tick_ignored", 16'(roll_f2), 16'h0000);
    btn_f = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-roll aborts with no result pulse.
    btn_s[2] = 1'b1;
    tick_run(2);
    repeat (3) @(negedge clk);
    check("abort_rolling", 16'(roll_s), 16'h0001);
    b_rv = rv_cnt_s;
    #3 rst_n = 1'b0;
    #1;
    check("abort_async", 16'({roll_s, rv_s, bcd_s}), 16'h0001);
    btn_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_pulse", 16'(rv_cnt_s - b_rv), 16'h0000);
    check("abort_idle",     16'({roll_s, sel_s}), 16'h0000);

    check("display_stable", 16'(disp_viol), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_roller_bcd.md
# dice_roller_bcd

Parametrised successor to the single-channel dice counter: seven debounced die-select buttons (d4, d6, d8, d10, d12, d20, d100) drive a BCD roll counter. The counter spins at clock rate while a button is held and latches on release, so the result depends on human press duration. The display width is configurable in BCD digits. The block sits between the pad inputs and `uo_out`, fed by the shared 32 Hz prescaler tick.

## Interface
- `DIGITS`, default 2: BCD digits on `bcd_out`; legal values 2..4.
- `DEB_COUNT`, default 3: consecutive equal tick-samples required to change a debounced level; legal values 1..15.
- `clk`  in  1  system clock, 32768 Hz.
- `rst_n`  in  1  reset, asynchronous, active-low; clears every register.
- `tick`  in  1  one-cycle debounce sample strobe from the prescaler.
- `btn`  in  7  raw buttons; bit i selects die i (order d4, d6, d8, d10, d12, d20, d100).
- `bcd_out`  out  4*DIGITS  displayed value, BCD, least-significant digit in [3:0].
- `die_sel`  out  3  index of the die locked for the current or last roll.
- `rolling`  out  1  high while in ROLLING.
- `result_valid`  out  1  one-cycle pulse when a new result is latched.

## Operation
- Debounce, per button:
  - Sample on `tick` only.
  - The debounced level flips after `DEB_COUNT` consecutive samples that differ from it.
  - A sample equal to the current level clears the count.
- FSM, two states:
  - IDLE → ROLLING: on a rising edge of any debounced button. The lowest set index wins and is locked into `die_sel`; in the same cycle, `cnt` loads that die's max value.
  - ROLLING: each cycle, `cnt` decrements in BCD; at value 1 it wraps to max.
  - Buttons other than the locked one are ignored while ROLLING.
  - ROLLING → IDLE: when the locked button's debounced level falls. That cycle, `bcd_out <= cnt` and `result_valid` pulses.
- A roll starts only on a rising edge. A second button still held on return to IDLE does not restart a roll.
- d100 range is 1..100:
  - With `DIGITS`=2, 100 displays as 00.
  - With `DIGITS`≥3, 100 displays as 100.
- `cnt` is 3 BCD digits internally and is truncated to `DIGITS` on output. Upper digits beyond 3 are 0.
- Reset values:
  - `bcd_out` = 1 (all upper digits 0).
  - `die_sel` = 0, `rolling` = 0, `result_valid` = 0.
  - Debounced levels 0, debounce counts 0, state IDLE.
- Reset mid-roll aborts immediately. No `result_valid` pulse is produced.

## Timing
- Button to debounced level: `DEB_COUNT` ticks after the input settles.
- Debounced rise to `rolling` high: 1 clk.
- Debounced fall to `result_valid` / `bcd_out` update: 1 clk, same edge that `rolling` falls.
- If `rolling` was high for n cycles, result = max − ((n−1) mod max).
- `tick` in the same cycle as reset release: the sample is ignored.

## Configuration
- `DICE_ROLL_ANIM_EN` defined:
  - During ROLLING, `bcd_out` follows `cnt`, updated on each `tick` only (visible spin at 32 Hz).
  - The final latch on release still takes the exact `cnt` value.
- Undefined: `bcd_out` holds the previous result throughout ROLLING.

## Structure
- Package `dice_pkg` holds:
  - `NUM_DIE`=7.
  - Die max table as BCD constants (4, 6, 8, 10, 12, 20, 100).
  - FSM state typedef (IDLE, ROLLING).
  - BCD decrement-with-wrap function.
- Sub-module `btn_debouncer`, parameter `DEB_COUNT`, seven instances. Ports: `clk`, `rst_n`, `tick`, `button`, `debounced`.

## Test plan
- Reset: `rst_n`=0 → `bcd_out`=8'h01, `rolling`=0, `result_valid`=0, `die_sel`=0.
- d6 roll, `DEB_COUNT`=2, `tick` every 4 clk: press `btn[1]`, hold until `rolling` has been high 8 cycles → `bcd_out`=8'h05, single `result_valid` pulse, `die_sel`=1.
- Glitch: `btn[3]` high for 1 tick only → `rolling` never asserts, `bcd_out` unchanged.
- d100 with n=1: `DIGITS`=2 → `bcd_out`=8'h00; `DIGITS`=3 → 12'h100. With n=2 → 99 in both.
- Simultaneous `btn[0]`+`btn[5]` rise → `die_sel`=0. Releasing only `btn[5]` keeps `rolling`=1. Releasing `btn[0]` gives result in 1..4, and no new roll while `btn[5]` stays held.
- Reset mid-roll → `rolling`=0 asynchronously, `bcd_out`=1, no `result_valid`.
- With `DICE_ROLL_ANIM_EN`: `bcd_out` changes only on `tick` cycles during ROLLING.
